// File: rtl/mem_access_stage.sv
// RV32 memory-access stage: single-outstanding req/ack data port, byte-lane steering, load extension.
// Optional misalignment trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_ALUOutput,
  input  logic [31:0] i_B,
  input  logic [2:0]  i_func3,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [4:0]  i_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WB} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        isLoad_q, isLoad_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        wbWe_q, wbWe_d;
  logic [31:0] wbData_q, wbData_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic [3:0]  laneBe;
  logic [31:0] laneData;
  logic [7:0]  selByte;
  logic [15:0] selHalf;
  logic [31:0] loadData;
  logic        misalign;

  // Store lane steering for the operation being presented by EX.
  always_comb begin
    laneBe   = 4'b1111;
    laneData = i_B;
    if (i_is_store) begin
      case (i_func3)
        3'd0: begin
          laneBe   = 4'b0001 << i_ALUOutput[1:0];
          laneData = {4{i_B[7:0]}};
        end
        3'd1: begin
          laneBe   = i_ALUOutput[1] ? 4'b1100 : 4'b0011;
          laneData = {2{i_B[15:0]}};
        end
        default: begin
          laneBe   = 4'b1111;
          laneData = i_B;
        end
      endcase
    end else begin
      laneData = 32'h0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic isHalf, isByte;
  always_comb begin
    isHalf   = i_is_store ? (i_func3 == 3'd1) : (i_func3 == 3'd1 || i_func3 == 3'd5);
    isByte   = i_is_store ? (i_func3 == 3'd0) : (i_func3 == 3'd0 || i_func3 == 3'd4);
    misalign = (i_is_load | i_is_store) &&
               (isHalf ? i_ALUOutput[0] : (!isByte && i_ALUOutput[1:0] != 2'b00));
  end
`else
  assign misalign = 1'b0;
`endif

  // Load extraction uses the offset and width latched at accept time.
  always_comb begin
    case (off_q)
      2'd0:    selByte = i_mem_rdata[7:0];
      2'd1:    selByte = i_mem_rdata[15:8];
      2'd2:    selByte = i_mem_rdata[23:16];
      default: selByte = i_mem_rdata[31:24];
    endcase
    selHalf = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (func3_q)
      3'd0:    loadData = {{24{selByte[7]}}, selByte};
      3'd1:    loadData = {{16{selHalf[15]}}, selHalf};
      3'd4:    loadData = {24'h0, selByte};
      3'd5:    loadData = {16'h0, selHalf};
      default: loadData = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    isLoad_d = isLoad_q;
    func3_d  = func3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    wbWe_d   = wbWe_q;
    wbData_d = wbData_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          rd_d     = i_rd;
          func3_d  = i_func3;
          off_d    = i_ALUOutput[1:0];
          isLoad_d = i_is_load & ~i_is_store;
          we_d     = i_is_store;
          addr_d   = {i_ALUOutput[31:2], 2'b00};
          be_d     = laneBe;
          wdata_d  = laneData;
          wbWe_d   = 1'b0;
          wbData_d = 32'h0;
          err_d    = 1'b0;
          cnt_d    = 16'h0;
          if (!i_is_load && !i_is_store) begin
            wbWe_d   = 1'b1;
            wbData_d = i_ALUOutput;
            state_d  = WB;
          end else if (misalign) begin
            err_d   = 1'b1;
            state_d = WB;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // An ack arriving on the final allowed cycle still completes normally.
        if (i_mem_ack) begin
          state_d = WB;
          if (isLoad_q) begin
            wbWe_d   = 1'b1;
            wbData_d = loadData;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = WB;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      isLoad_q <= 1'b0;
      func3_q  <= 3'h0;
      off_q    <= 2'h0;
      rd_q     <= 5'h0;
      wbWe_q   <= 1'b0;
      wbData_q <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= 16'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      isLoad_q <= isLoad_d;
      func3_q  <= func3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      wbWe_q   <= wbWe_d;
      wbData_q <= wbData_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_mem_req   = (state_q == REQ);
  assign o_mem_we    = we_q & o_mem_req;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;
  assign o_wb_valid  = (state_q == WB);
  assign o_wb_we     = wbWe_q & o_wb_valid;
  assign o_wb_rd     = rd_q;
  assign o_wb_data   = wbData_q;
  assign o_bus_err   = err_q & o_wb_valid;

endmodule
